// File: rtl/muldiv32.sv
// Iterative multiply/divide unit: MULT/MULTU/DIV/DIVU over a fixed 33-edge latency.
// Magnitudes are processed unsigned; signs are applied in the FIX cycle.
module muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  p;
    logic [WIDTH-1:0]    mb;
    logic                isdiv;
    logic                negq;
    logic                negr;
    logic                bz;

    logic                sgn;
    logic [WIDTH-1:0]    a_abs;
    logic [WIDTH-1:0]    b_abs;
    logic [WIDTH:0]      msum;
    logic [WIDTH:0]      rsh;
    logic [WIDTH:0]      dif;
    logic                ge;
    logic [2*WIDTH-1:0]  step_nxt;
    logic [2*WIDTH-1:0]  pneg;
    logic [WIDTH-1:0]    qv;
    logic [WIDTH-1:0]    rv;
    logic [WIDTH-1:0]    fix_hi;
    logic [WIDTH-1:0]    fix_lo;

    always_comb begin
        sgn   = ~op[0];
        a_abs = (sgn && A[WIDTH-1]) ? -A : A;
        b_abs = (sgn && B[WIDTH-1]) ? -B : B;
    end

    // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        msum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mb : {WIDTH{1'b0}})};
        rsh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        dif  = rsh - {1'b0, mb};
        ge   = ~dif[WIDTH] | bz;
        if (isdiv) begin
            step_nxt = {(ge ? dif[WIDTH-1:0] : rsh[WIDTH-1:0]), p[WIDTH-2:0], ge};
        end else begin
            step_nxt = {msum, p[WIDTH-1:1]};
        end
    end

    always_comb begin
        pneg = -p;
        qv   = p[WIDTH-1:0];
        rv   = p[2*WIDTH-1:WIDTH];
        if (isdiv) begin
            fix_lo = bz ? {WIDTH{1'b1}} : (negq ? -qv : qv);
            fix_hi = negr ? -rv : rv;
        end else begin
            {fix_hi, fix_lo} = negq ? pneg : p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            p        <= '0;
            mb       <= '0;
            isdiv    <= 1'b0;
            negq     <= 1'b0;
            negr     <= 1'b0;
            bz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        p        <= {{WIDTH{1'b0}}, a_abs};
                        mb       <= b_abs;
                        isdiv    <= op[1];
                        negq     <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        negr     <= sgn & A[WIDTH-1];
                        bz       <= (B == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    p   <= step_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    div_zero <= isdiv & bz;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv32.sv
// Scoreboard bench for muldiv32: expected {div_zero,hi,lo} queued at launch,
// popped and compared when done pulses.
module tb_muldiv32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    logic [64:0] sb_q[$];

    muldiv32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] sp;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic [63:0]        up;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        case (o)
            2'd0: begin
                sp = sa * sbv;
                return {1'b0, sp};
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sbv;
                sr = sa % sbv;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        sb_q.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts edges until done is seen.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = busy ? 1 : 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) nb++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'd1;
        A     = 32'h1234;
        B     = 32'h5678;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, div_zero});
        end
        total++;
        if ({hi, lo} !== 64'd0) begin
            bad++;
            $display("FAIL reset_hilo got=%h want=0", {hi, lo});
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_mul;
        logic [1:0]  to[5];
        logic [31:0] ta[5];
        logic [31:0] tb[5];
        logic [64:0] e;
        int n, nb;
        to = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_FFFF};
        tb = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            launch(to[i], ta[i], tb[i]);
            wait_done(n, nb);
            e = sb_q.pop_front();
            total++;
            if (n !== 33) begin
                bad++;
                $display("FAIL mul_latency[%0d] got=%0d want=33", i, n);
            end
            total++;
            if (nb !== 33) begin
                bad++;
                $display("FAIL mul_busy_cycles[%0d] got=%0d want=33", i, nb);
            end
            total++;
            if ({div_zero, hi, lo} !== e) begin
                bad++;
                $display("FAIL mul_result[%0d] got=%b_%h_%h want=%b_%h_%h",
                         i, div_zero, hi, lo, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_div;
        logic [1:0]  to[6];
        logic [31:0] ta[6];
        logic [31:0] tb[6];
        logic [64:0] e;
        int n, nb;
        to = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2};
        ta = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'd5, 32'hFFFF_FF9C};
        tb = '{32'h0000_0002, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd9, 32'hFFFF_FFF9};
        for (int i = 0; i < 6; i++) begin
            launch(to[i], ta[i], tb[i]);
            wait_done(n, nb);
            e = sb_q.pop_front();
            total++;
            if (n !== 33) begin
                bad++;
                $display("FAIL div_latency[%0d] got=%0d want=33", i, n);
            end
            total++;
            if ({div_zero, hi, lo} !== e) begin
                bad++;
                $display("FAIL div_result[%0d] got=%b_%h_%h want=%b_%h_%h",
                         i, div_zero, hi, lo, e[64], e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_divzero;
        logic [1:0]  to[2];
        logic [31:0] ta[2];
        logic [64:0] e;
        logic [63:0] held;
        int n, nb;
        to = '{2'd3, 2'd2};
        ta = '{32'h1234_5678, 32'hFFFF_FFF0};
        for (int i = 0; i < 2; i++) begin
            launch(to[i], ta[i], 32'd0);
            wait_done(n, nb);
            e = sb_q.pop_front();
            total++;
            if (n !== 33) begin
                bad++;
                $display("FAIL dz_latency[%0d] got=%0d want=33", i, n);
            end
            total++;
            if ({div_zero, hi, lo} !== e) begin
                bad++;
                $display("FAIL dz_result[%0d] got=%b_%h_%h want=%b_%h_%h",
                         i, div_zero, hi, lo, e[64], e[63:32], e[31:0]);
            end
        end
        held = {hi, lo};
        launch(2'd1, 32'd3, 32'd5);
        total++;
        if (div_zero !== 1'b0) begin
            bad++;
            $display("FAIL dz_clear_on_start got=%b want=0", div_zero);
        end
        total++;
        if ({hi, lo} !== held) begin
            bad++;
            $display("FAIL dz_hold_hilo got=%h want=%h", {hi, lo}, held);
        end
        wait_done(n, nb);
        e = sb_q.pop_front();
        total++;
        if ({div_zero, hi, lo} !== e) begin
            bad++;
            $display("FAIL dz_next_mul got=%b_%h_%h want=%b_%h_%h",
                     div_zero, hi, lo, e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [64:0] e;
        int n, nb;
        @(negedge clk);
        op    = 2'd1;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_1000;
        start = 1'b1;
        sb_q.push_back(model(2'd1, 32'hDEAD_BEEF, 32'h0000_1000));
        @(posedge clk);
        #1;
        op = 2'd2;
        A  = 32'hFFFF_FC00;
        B  = 32'h0000_0003;
        sb_q.push_back(model(2'd2, 32'hFFFF_FC00, 32'h0000_0003));
        wait_done(n, nb);
        e = sb_q.pop_front();
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL b2b_first_latency got=%0d want=33", n);
        end
        total++;
        if ({div_zero, hi, lo} !== e) begin
            bad++;
            $display("FAIL b2b_first_result got=%b_%h_%h want=%b_%h_%h",
                     div_zero, hi, lo, e[64], e[63:32], e[31:0]);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_accept got=%b want=10", {busy, done});
        end
        total++;
        if ({hi, lo} !== e[63:0]) begin
            bad++;
            $display("FAIL b2b_hold got=%h want=%h", {hi, lo}, e[63:0]);
        end
        wait_done(n, nb);
        e = sb_q.pop_front();
        total++;
        if (n !== 33) begin
            bad++;
            $display("FAIL b2b_second_latency got=%0d want=33", n);
        end
        total++;
        if ({div_zero, hi, lo} !== e) begin
            bad++;
            $display("FAIL b2b_second_result got=%b_%h_%h want=%b_%h_%h",
                     div_zero, hi, lo, e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_ignore_start;
        logic [64:0] e;
        int n, nb, extra;
        launch(2'd0, 32'hFFFF_0000, 32'h0000_0100);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        op    = 2'd3;
        A     = 32'd50;
        B     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, nb);
        e = sb_q.pop_front();
        total++;
        if (n !== 22) begin
            bad++;
            $display("FAIL ign_latency got=%0d want=22", n);
        end
        total++;
        if ({div_zero, hi, lo} !== e) begin
            bad++;
            $display("FAIL ign_result got=%b_%h_%h want=%b_%h_%h",
                     div_zero, hi, lo, e[64], e[63:32], e[31:0]);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL ign_extra_activity got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_mid;
        logic [64:0] e;
        int n, nb, extra;
        launch(2'd1, 32'hCAFE_F00D, 32'h1357_9BDF);
        e = sb_q.pop_front();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({busy, done, div_zero} !== 3'b000) begin
            bad++;
            $display("FAIL rmid_flags got=%b want=000", {busy, done, div_zero});
        end
        total++;
        if ({hi, lo} !== 64'd0) begin
            bad++;
            $display("FAIL rmid_hilo got=%h want=0", {hi, lo});
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'd3;
        A     = 32'd9;
        B     = 32'd0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL rmid_no_done got=%0d want=0", extra);
        end
        launch(2'd2, 32'h8000_0001, 32'h0000_0010);
        wait_done(n, nb);
        e = sb_q.pop_front();
        total++;
        if ({div_zero, hi, lo} !== e || n !== 33) begin
            bad++;
            $display("FAIL rmid_after got=%b_%h_%h n=%0d want=%b_%h_%h n=33",
                     div_zero, hi, lo, n, e[64], e[63:32], e[31:0]);
        end
    endtask

    task automatic test_random;
        logic [64:0] e;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int n, nb;
        for (int i = 0; i < 12; i++) begin
            o = 2'($urandom_range(3, 0));
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : $urandom >> $urandom_range(31, 0);
            launch(o, a, b);
            wait_done(n, nb);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rnd_queue_empty[%0d] got=0 want=1", i);
            end else begin
                e = sb_q.pop_front();
                total++;
                if ({div_zero, hi, lo} !== e || n !== 33) begin
                    bad++;
                    $display("FAIL rnd[%0d] op=%0d a=%h b=%h got=%b_%h_%h n=%0d want=%b_%h_%h",
                             i, o, a, b, div_zero, hi, lo, n, e[64], e[63:32], e[31:0]);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        A     = 32'd0;
        B     = 32'd0;
        test_reset;
        test_mul;
        test_div;
        test_divzero;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
